// File: rtl/alu_ctrl_fsm.sv
// Control sequencer for the AND/OR/NEG ALU datapath: fetch, decode, execute, write-back.
// Strobes are registered from the next state so every output is a clean flop.
module alu_ctrl_fsm #(
  parameter logic [4:0]  OP_AND = 5'b01000,
  parameter logic [4:0]  OP_OR  = 5'b01001,
  parameter logic [4:0]  OP_NEG = 5'b10000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rout,
  output logic             Rin,
  output logic             Yin,
  output logic             AND,
  output logic             OR,
  output logic             NEG,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_ILL
  } state_t;

  typedef enum logic [1:0] {
    OPK_NONE, OPK_AND, OPK_OR, OPK_NEG
  } opk_t;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, rd, mdr_in, mdr_out, ir_in;
    logic gra, grb, grc, r_out, r_in, y_in;
    logic and_s, or_s, neg_s, busy, done, illegal;
  } ctrl_t;

  state_t           state_q, state_d;
  opk_t             op_q, op_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] retired_q;
  logic [4:0]       opcode;
  logic             unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  // Next state, opcode latch and next-cycle strobes decoded from the state being entered.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctrl_d  = '0;

    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2: begin
        // IR is bypassed, so the opcode presented during T2 is the one being loaded.
        if (opcode == OP_AND) begin
          op_d    = OPK_AND;
          state_d = S_T3;
        end else if (opcode == OP_OR) begin
          op_d    = OPK_OR;
          state_d = S_T3;
        end else if (opcode == OP_NEG) begin
          op_d    = OPK_NEG;
          state_d = S_T4;
        end else begin
          state_d = S_ILL;
        end
      end
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_IDLE;
      S_ILL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ctrl_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_T0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
        ctrl_d.z_in   = 1'b1;
      end
      S_T1: begin
        ctrl_d.rd       = 1'b1;
        ctrl_d.mdr_in   = 1'b1;
        ctrl_d.zlow_out = (state_q == S_T0);
        ctrl_d.pc_in    = (state_q == S_T0);
      end
      S_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      S_T3: begin
        ctrl_d.grb   = 1'b1;
        ctrl_d.r_out = 1'b1;
        ctrl_d.y_in  = 1'b1;
      end
      S_T4: begin
        ctrl_d.r_out = 1'b1;
        ctrl_d.z_in  = 1'b1;
        ctrl_d.grb   = (op_d == OPK_NEG);
        ctrl_d.grc   = (op_d != OPK_NEG);
        ctrl_d.and_s = (op_d == OPK_AND);
        ctrl_d.or_s  = (op_d == OPK_OR);
        ctrl_d.neg_s = (op_d == OPK_NEG);
      end
      S_T5: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.gra      = 1'b1;
        ctrl_d.r_in     = 1'b1;
        ctrl_d.done     = 1'b1;
      end
      S_ILL:   ctrl_d.illegal = 1'b1;
      default: ;
    endcase
  end

  // State, opcode, strobe and retired-count registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      op_q      <= OPK_NONE;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
      if (state_q == S_T5) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign PCout   = ctrl_q.pc_out;
  assign MARin   = ctrl_q.mar_in;
  assign IncPC   = ctrl_q.inc_pc;
  assign Zin     = ctrl_q.z_in;
  assign Zlowout = ctrl_q.zlow_out;
  assign PCin    = ctrl_q.pc_in;
  assign Read    = ctrl_q.rd;
  assign MDRin   = ctrl_q.mdr_in;
  assign MDRout  = ctrl_q.mdr_out;
  assign IRin    = ctrl_q.ir_in;
  assign Gra     = ctrl_q.gra;
  assign Grb     = ctrl_q.grb;
  assign Grc     = ctrl_q.grc;
  assign Rout    = ctrl_q.r_out;
  assign Rin     = ctrl_q.r_in;
  assign Yin     = ctrl_q.y_in;
  assign AND     = ctrl_q.and_s;
  assign OR      = ctrl_q.or_s;
  assign NEG     = ctrl_q.neg_s;
  assign busy    = ctrl_q.busy;
  assign done    = ctrl_q.done;
  assign illegal = ctrl_q.illegal;
  assign retired = retired_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: per-cycle strobe sequences, stalls, reset, back-to-back, counter wrap.
module tb_alu_ctrl_fsm;

  logic        clk, clr, start, mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
  logic Gra, Grb, Grc, Rout, Rin, Yin, AND, OR, NEG, busy, done, illegal;
  logic [15:0] retired;
  logic PCout2, MARin2, IncPC2, Zin2, Zlowout2, PCin2, Read2, MDRin2, MDRout2, IRin2;
  logic Gra2, Grb2, Grc2, Rout2, Rin2, Yin2, AND2, OR2, NEG2, busy2, done2, illegal2;
  logic [1:0] retired2;

  typedef struct packed {
    logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rout, Rin, Yin, AND_s, OR_s, NEG_s, busy, done, illegal;
  } obs_t;

  obs_t obs;
  assign obs = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
                Gra, Grb, Grc, Rout, Rin, Yin, AND, OR, NEG, busy, done, illegal};

  int n_tests = 0;
  int n_fail  = 0;

  localparam int K_AND = 0;
  localparam int K_OR  = 1;
  localparam int K_NEG = 2;

  alu_ctrl_fsm u_dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .Rin(Rin), .Yin(Yin),
    .AND(AND), .OR(OR), .NEG(NEG), .busy(busy), .done(done), .illegal(illegal),
    .retired(retired)
  );

  alu_ctrl_fsm #(.CNT_W(2)) u_dut2 (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout2), .MARin(MARin2), .IncPC(IncPC2), .Zin(Zin2), .Zlowout(Zlowout2),
    .PCin(PCin2), .Read(Read2), .MDRin(MDRin2), .MDRout(MDRout2), .IRin(IRin2),
    .Gra(Gra2), .Grb(Grb2), .Grc(Grc2), .Rout(Rout2), .Rin(Rin2), .Yin(Yin2),
    .AND(AND2), .OR(OR2), .NEG(NEG2), .busy(busy2), .done(done2), .illegal(illegal2),
    .retired(retired2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1ns after the next rising edge; outputs then show the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t e_t0();
    obs_t e = '0;
    e.PCout = 1'b1; e.MARin = 1'b1; e.IncPC = 1'b1; e.Zin = 1'b1; e.busy = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_t1(input bit first);
    obs_t e = '0;
    e.Read = 1'b1; e.MDRin = 1'b1; e.busy = 1'b1;
    e.Zlowout = first; e.PCin = first;
    return e;
  endfunction

  function automatic obs_t e_t2();
    obs_t e = '0;
    e.MDRout = 1'b1; e.IRin = 1'b1; e.busy = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_t3();
    obs_t e = '0;
    e.Grb = 1'b1; e.Rout = 1'b1; e.Yin = 1'b1; e.busy = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_t4(input int k);
    obs_t e = '0;
    e.Rout = 1'b1; e.Zin = 1'b1; e.busy = 1'b1;
    if (k == K_NEG) begin e.Grb = 1'b1; e.NEG_s = 1'b1; end
    else if (k == K_OR) begin e.Grc = 1'b1; e.OR_s = 1'b1; end
    else begin e.Grc = 1'b1; e.AND_s = 1'b1; end
    return e;
  endfunction

  function automatic obs_t e_t5();
    obs_t e = '0;
    e.Zlowout = 1'b1; e.Gra = 1'b1; e.Rin = 1'b1; e.done = 1'b1; e.busy = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_ill();
    obs_t e = '0;
    e.illegal = 1'b1; e.busy = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    clr = 1'b1; start = 1'b1;
    step(); step();
    clr = 1'b0; start = 1'b0;
    n_tests++;
    if (obs !== obs_t'(0)) begin
      n_fail++; $display("FAIL reset_outs: got %h want 0", obs);
    end
    n_tests++;
    if (retired !== 16'd0 || retired2 !== 2'd0) begin
      n_fail++; $display("FAIL reset_retired: got %0d/%0d want 0/0", retired, retired2);
    end
  endtask

  task automatic test_reset_midwait();
    ir = {5'b01000, 27'h0000123}; mem_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    n_tests++;
    if (obs !== e_t1(1'b0)) begin
      n_fail++; $display("FAIL midwait_in_t1: got %h want %h", obs, e_t1(1'b0));
    end
    clr = 1'b1;
    step();
    clr = 1'b0; mem_ready = 1'b1;
    n_tests++;
    if (obs !== obs_t'(0) || retired !== 16'd0) begin
      n_fail++; $display("FAIL midwait_clr: got %h/%0d want 0/0", obs, retired);
    end
    step();
    n_tests++;
    if (obs !== obs_t'(0)) begin
      n_fail++; $display("FAIL midwait_stays_idle: got %h want 0", obs);
    end
  endtask

  task automatic test_and();
    obs_t exp_q[$];
    exp_q = '{e_t0(), e_t1(1'b1), e_t2(), e_t3(), e_t4(K_AND), e_t5(), obs_t'(0)};
    ir = {5'b01000, 27'h0000123}; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      start = 1'b0;
      n_tests++;
      if (obs !== exp_q[i]) begin
        n_fail++; $display("FAIL and_cyc%0d: got %h want %h", i + 1, obs, exp_q[i]);
      end
    end
    n_tests++;
    if (retired !== 16'd1) begin
      n_fail++; $display("FAIL and_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_neg_stall();
    obs_t exp_q[$];
    exp_q = '{e_t0(), e_t1(1'b1), e_t1(1'b0), e_t1(1'b0), e_t1(1'b0),
              e_t2(), e_t4(K_NEG), e_t5(), obs_t'(0)};
    ir = {5'b10000, 27'h0000456}; mem_ready = 1'b0; start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      start = 1'b0;
      if (i + 1 == 5) mem_ready = 1'b1;
      n_tests++;
      if (obs !== exp_q[i]) begin
        n_fail++; $display("FAIL neg_cyc%0d: got %h want %h", i + 1, obs, exp_q[i]);
      end
    end
    n_tests++;
    if (retired !== 16'd2) begin
      n_fail++; $display("FAIL neg_retired: got %0d want 2", retired);
    end
  endtask

  task automatic test_illegal();
    obs_t exp_q[$];
    exp_q = '{e_t0(), e_t1(1'b1), e_t2(), e_ill(), obs_t'(0)};
    ir = {5'b11111, 27'h7ffffff}; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      start = 1'b0;
      n_tests++;
      if (obs !== exp_q[i]) begin
        n_fail++; $display("FAIL ill_cyc%0d: got %h want %h", i + 1, obs, exp_q[i]);
      end
    end
    n_tests++;
    if (retired !== 16'd2) begin
      n_fail++; $display("FAIL ill_retired: got %0d want 2", retired);
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp_q[$];
    int   done_cyc[$];
    exp_q = '{e_t0(), e_t1(1'b1), e_t2(), e_t3(), e_t4(K_OR), e_t5(), obs_t'(0),
              e_t0(), e_t1(1'b1), e_t2(), e_t3(), e_t4(K_AND), e_t5(), obs_t'(0)};
    ir = {5'b01001, 27'h0000789}; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      if (i + 1 == 7) ir = {5'b01000, 27'h0000abc};
      if (i + 1 == 8) start = 1'b0;
      if (done) done_cyc.push_back(i + 1);
      n_tests++;
      if (obs !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_cyc%0d: got %h want %h", i + 1, obs, exp_q[i]);
      end
    end
    n_tests++;
    if (done_cyc.size() != 2 || done_cyc[1] - done_cyc[0] != 7) begin
      n_fail++; $display("FAIL b2b_done_gap: got %0d pulses want 2 pulses 7 apart", done_cyc.size());
    end
    n_tests++;
    if (retired !== 16'd4) begin
      n_fail++; $display("FAIL b2b_retired: got %0d want 4", retired);
    end
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp2[4];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd0};
    clr = 1'b1;
    step();
    clr = 1'b0;
    ir = {5'b01000, 27'h0000001}; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (6) step();
      n_tests++;
      if (retired2 !== exp2[k] || retired !== 16'(k + 1)) begin
        n_fail++;
        $display("FAIL wrap_%0d: got %0d/%0d want %0d/%0d", k + 1, retired2, retired, exp2[k], k + 1);
      end
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mem_ready = 1'b1; ir = 32'd0;
    test_reset();
    test_reset_midwait();
    test_and();
    test_neg_stall();
    test_illegal();
    test_back_to_back();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
